// File: rtl/game_ctrl_if.sv
// Signal bundle between the game session sequencer and its surroundings:
// button/event inputs, the timer datapath handshake and the display values.
// The master modport is the sequencer; the slave modport is the environment
// (buttons, hit detector, timer datapath, display).
interface game_ctrl_if;
  logic        start;
  logic        pause;
  logic        hit;
  logic        miss;
  logic [20:0] timer_in;
  logic        timer_load;
  logic [20:0] load_value;
  logic        timer_run;
  logic        game_over;
  logic [2:0]  state;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;

  modport master (
    input  start, pause, hit, miss, timer_in,
    output timer_load, load_value, timer_run, game_over, state,
           hit_count, miss_count
  );

  modport slave (
    output start, pause, hit, miss, timer_in,
    input  timer_load, load_value, timer_run, game_over, state,
           hit_count, miss_count
  );
endinterface

// File: rtl/game_ctrl.sv
// Session sequencer for the down-counting game timer.
// IDLE -> READY (fixed delay) -> RUN <-> PAUSE -> OVER, restartable from OVER.
// Loads the timer with the session length, gates its countdown, applies the
// per-miss time penalty by reloading a reduced value, and keeps hit/miss tallies.
// Optional feature: define MISS_LIMIT_EN to end the session once the miss
// count reaches MAX_MISS.
// All outputs are registered; reset is synchronous and active-low.
module game_ctrl #(
  parameter int TIMER_INIT   = 1800000,
  parameter int MISS_PENALTY = 50000,
  parameter int READY_CYCLES = 150000000,
  parameter int MAX_MISS     = 10
) (
  input  logic          clock,
  input  logic          reset,
  game_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [20:0] INIT_VAL  = 21'(TIMER_INIT);
  localparam logic [20:0] PEN_VAL   = 21'(MISS_PENALTY);
  localparam logic [31:0] READY_TOP = 32'(READY_CYCLES - 1);

  state_t      state, state_n;
  logic        start_q, pause_q;
  logic [31:0] ready_cnt, ready_cnt_n;
  logic        timer_load, timer_load_n;
  logic [20:0] load_value, load_value_n;
  logic        timer_run, timer_run_n;
  logic        game_over, game_over_n;
  logic [7:0]  hit_count, hit_count_n;
  logic [7:0]  miss_count, miss_count_n;

  logic        start_rise, pause_rise;
  logic [7:0]  hit_inc, miss_inc;
  logic [20:0] penalized;

  // Button edges: the previous-value registers come out of reset high, so a
  // button held through reset must be released before it can trigger.
  assign start_rise = bus.start & ~start_q;
  assign pause_rise = bus.pause & ~pause_q;

  // Saturating increments and the non-wrapping penalty subtraction.
  assign hit_inc   = (hit_count  == 8'hFF) ? hit_count  : hit_count  + 8'd1;
  assign miss_inc  = (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
  assign penalized = (bus.timer_in > PEN_VAL) ? bus.timer_in - PEN_VAL : 21'd0;

  // State register and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      start_q    <= 1'b1;
      pause_q    <= 1'b1;
      ready_cnt  <= '0;
      timer_load <= 1'b0;
      load_value <= '0;
      timer_run  <= 1'b0;
      game_over  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_n;
      start_q    <= bus.start;
      pause_q    <= bus.pause;
      ready_cnt  <= ready_cnt_n;
      timer_load <= timer_load_n;
      load_value <= load_value_n;
      timer_run  <= timer_run_n;
      game_over  <= game_over_n;
      hit_count  <= hit_count_n;
      miss_count <= miss_count_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n      = state;
    ready_cnt_n  = ready_cnt;
    timer_load_n = 1'b0;
    load_value_n = load_value;
    hit_count_n  = hit_count;
    miss_count_n = miss_count;

    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          timer_load_n = 1'b1;
          load_value_n = INIT_VAL;
          hit_count_n  = '0;
          miss_count_n = '0;
          ready_cnt_n  = READY_TOP;
          state_n      = READY;
        end
      end

      READY: begin
        if (ready_cnt == '0) state_n = RUN;
        else                 ready_cnt_n = ready_cnt - 32'd1;
      end

      RUN: begin
        if (bus.timer_in == '0) begin
          // Expiry wins: nothing else this cycle is counted or loaded.
          state_n = OVER;
        end else begin
          if (bus.hit) hit_count_n = hit_inc;
          if (bus.miss) begin
            miss_count_n = miss_inc;
            timer_load_n = 1'b1;
            load_value_n = penalized;
          end
`ifdef MISS_LIMIT_EN
          if (bus.miss && miss_inc == 8'(MAX_MISS)) state_n = OVER;
          else if (pause_rise)                      state_n = PAUSE;
`else
          if (pause_rise) state_n = PAUSE;
`endif
        end
      end

      PAUSE: begin
        if (pause_rise) state_n = RUN;
      end

      default: state_n = IDLE;
    endcase

    timer_run_n = (state_n == RUN);
    game_over_n = (state_n == OVER);
  end

  assign bus.state      = state;
  assign bus.timer_load = timer_load;
  assign bus.load_value = load_value;
  assign bus.timer_run  = timer_run;
  assign bus.game_over  = game_over;
  assign bus.hit_count  = hit_count;
  assign bus.miss_count = miss_count;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with READY_CYCLES = 4, TIMER_INIT = 100,
// MISS_PENALTY = 30, MAX_MISS = 3. Expected values are hand-computed.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. one full cycle after the edge that produced them.
module tb_game_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  game_ctrl_if bus ();

  game_ctrl #(
    .TIMER_INIT  (100),
    .MISS_PENALTY(30),
    .READY_CYCLES(4),
    .MAX_MISS    (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, " state"},      32'(bus.state),      0);
    check({tag, " timer_load"}, 32'(bus.timer_load), 0);
    check({tag, " load_value"}, 32'(bus.load_value), 0);
    check({tag, " timer_run"},  32'(bus.timer_run),  0);
    check({tag, " game_over"},  32'(bus.game_over),  0);
    check({tag, " hit_count"},  32'(bus.hit_count),  0);
    check({tag, " miss_count"}, 32'(bus.miss_count), 0);
  endtask

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b1;
    bus.pause    = 1'b0;
    bus.hit      = 1'b0;
    bus.miss     = 1'b0;
    bus.timer_in = 21'd100;
    reset        = 1'b0;

    // Reset with start held.
    tick();
    tick();
    check_all_idle("reset");

    // Start still held after reset: no edge.
    reset = 1'b1;
    tick();
    check("held start state", 32'(bus.state), 0);
    check("held start load",  32'(bus.timer_load), 0);

    // Release and press.
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    check("press load",       32'(bus.timer_load), 1);
    check("press load_value", 32'(bus.load_value), 100);
    check("press state",      32'(bus.state), 1);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ready state", 32'(bus.state), 1);
      check("ready load",  32'(bus.timer_load), 0);
    end
    tick();
    check("run state", 32'(bus.state), 2);
    check("run timer_run", 32'(bus.timer_run), 1);

    // Miss penalty above the penalty size.
    bus.timer_in = 21'd70;
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("miss70 load",       32'(bus.timer_load), 1);
    check("miss70 load_value", 32'(bus.load_value), 40);
    check("miss70 miss_count", 32'(bus.miss_count), 1);
    tick();
    check("load pulse width", 32'(bus.timer_load), 0);
    check("load_value hold",  32'(bus.load_value), 40);

    // Miss penalty clamped at zero.
    bus.timer_in = 21'd20;
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("miss20 load",       32'(bus.timer_load), 1);
    check("miss20 load_value", 32'(bus.load_value), 0);
    check("miss20 miss_count", 32'(bus.miss_count), 2);

    // Pause edge with a hit in the same cycle.
    bus.timer_in = 21'd50;
    bus.pause = 1'b1;
    bus.hit   = 1'b1;
    tick();
    bus.hit = 1'b0;
    check("pause state",     32'(bus.state), 3);
    check("pause timer_run", 32'(bus.timer_run), 0);
    check("pause hit_count", 32'(bus.hit_count), 1);

    // Miss ignored while paused.
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("paused miss_count", 32'(bus.miss_count), 2);
    check("paused load",       32'(bus.timer_load), 0);
    check("paused state",      32'(bus.state), 3);

    // Second pause edge resumes.
    bus.pause = 1'b0;
    tick();
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    check("resume state",     32'(bus.state), 2);
    check("resume timer_run", 32'(bus.timer_run), 1);

    // Expiry with a same-cycle miss.
    bus.timer_in = 21'd0;
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("expiry state",      32'(bus.state), 4);
    check("expiry game_over",  32'(bus.game_over), 1);
    check("expiry timer_run",  32'(bus.timer_run), 0);
    check("expiry miss_count", 32'(bus.miss_count), 2);
    check("expiry load",       32'(bus.timer_load), 0);
    tick();
    check("over hold hit_count", 32'(bus.hit_count), 1);

    // Restart from OVER.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart state",      32'(bus.state), 1);
    check("restart game_over",  32'(bus.game_over), 0);
    check("restart hit_count",  32'(bus.hit_count), 0);
    check("restart miss_count", 32'(bus.miss_count), 0);
    check("restart load_value", 32'(bus.load_value), 100);
    for (int i = 0; i < 4; i++) tick();
    check("restart run", 32'(bus.state), 2);

    // Plain hit in RUN.
    bus.timer_in = 21'd90;
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    check("run hit_count", 32'(bus.hit_count), 1);

    // Three misses: the limit ends the session only with MISS_LIMIT_EN.
    for (int i = 0; i < 3; i++) begin
      bus.miss = 1'b1;
      tick();
      bus.miss = 1'b0;
      check("limit load_value", 32'(bus.load_value), 60);
      if (i < 2) tick();
    end
    check("limit miss_count", 32'(bus.miss_count), 3);
`ifdef MISS_LIMIT_EN
    check("limit state",     32'(bus.state), 4);
    check("limit game_over", 32'(bus.game_over), 1);
`else
    check("limit state",     32'(bus.state), 2);
    check("limit game_over", 32'(bus.game_over), 0);
    bus.timer_in = 21'd0;
    tick();
    check("late expiry state", 32'(bus.state), 4);
`endif

    // Enter READY, then reset mid-operation.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("pre-reset state", 32'(bus.state), 1);
    tick();
    reset = 1'b0;
    tick();
    check_all_idle("mid reset");
    reset = 1'b1;
    tick();
    check("post reset state", 32'(bus.state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Session sequencer for the down-counting game timer and its seven-segment display path. Start and pause buttons and hit/miss events drive a five-state machine: IDLE, READY, RUN, PAUSE, OVER. The block loads the timer with the session time, gates its countdown, and applies the time penalty for each miss by reloading a reduced value. It also keeps the hit/miss tallies and raises `game_over` when the session ends.

## Interface
- `TIMER_INIT`, 1800000: session length in timer ticks (0.1 ms units, 180 s).
- `MISS_PENALTY`, 50000: ticks removed per miss (5 s).
- `READY_CYCLES`, 150000000: clock cycles spent in READY before RUN (3 s at 50 MHz); legal range ≥1.
- `MAX_MISS`, 10: miss count that ends the session (used only with `MISS_LIMIT_EN`).
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-low reset; one clock, synchronous, active-low.
- `start` in 1: debounced start button level; acted on at its rising edge.
- `pause` in 1: debounced pause button level; acted on at its rising edge.
- `hit` in 1: single-cycle hit event.
- `miss` in 1: single-cycle miss event.
- `timer_in` in 21: current remaining ticks from the timer datapath.
- `timer_load` out 1: one-cycle pulse; the timer loads `load_value`.
- `load_value` out 21: value to load; valid while `timer_load` = 1.
- `timer_run` out 1: level; the timer decrements on its ticks only while this is high.
- `game_over` out 1: high in OVER.
- `state` out 3: IDLE = 0, READY = 1, RUN = 2, PAUSE = 3, OVER = 4.
- `hit_count` out 8: hits this session, saturating at 255.
- `miss_count` out 8: misses this session, saturating at 255.

## Operation
- **Edge detection:** internal previous-value registers on `start` and `pause` reset to 1. A button held through reset therefore generates no edge until it is released and pressed again.
- **IDLE:** a `start` edge pulses `timer_load` with `load_value` = `TIMER_INIT`, clears both counts, loads the ready counter with `READY_CYCLES`-1, and moves to READY.
- **READY:** the ready counter decrements each cycle. At 0 the block enters RUN and sets `timer_run` = 1. All other inputs are ignored.
- **RUN, `hit`:** `hit_count` increments.
- **RUN, `miss`:**
  - `miss_count` increments.
  - `timer_load` pulses with `load_value` = `timer_in` − `MISS_PENALTY` when `timer_in` > `MISS_PENALTY`, else 0.
  - Width is 21 bits; the subtraction never wraps.
- **RUN, `pause` edge:** `timer_run` = 0 and the block enters PAUSE. A `miss` or `hit` in the same cycle is still processed.
- **RUN, end of session:**
  - `timer_in` == 0 sends the block to OVER.
  - With `MISS_LIMIT_EN`, the post-increment `miss_count` == `MAX_MISS` also sends it to OVER.
  - `timer_in` == 0 takes priority over a same-cycle `miss`: no count, no load.
- **PAUSE:** a `pause` edge returns to RUN with `timer_run` = 1. `start`, `hit` and `miss` are ignored.
- **OVER:**
  - `game_over` = 1 and `timer_run` = 0.
  - Counts hold for display.
  - A `start` edge behaves exactly as in IDLE: reload, clear counts, go to READY, `game_over` = 0.
- **Simultaneous `hit` and `miss`:** both counts update and the penalty applies.
- **Reset mid-operation:** an asserted `reset` overrides every state on the next edge.

## Timing
- Outputs after reset: `state` = IDLE, `timer_load` = 0, `load_value` = 0, `timer_run` = 0, `game_over` = 0, both counts = 0.
- All outputs are registered. An input sampled at edge k is reflected in the outputs immediately after edge k, so latency is 1 cycle.
- `timer_load` is high for exactly one cycle per load event. `load_value` holds its last value otherwise.
- READY lasts exactly `READY_CYCLES` cycles, counted from the first cycle `state` = 1 through the last.
- The timer datapath gives `timer_load` priority over its decrement in the same cycle.
- `timer_run` is high only in RUN.

## Configuration
- **`MISS_LIMIT_EN` defined:** reaching `MAX_MISS` misses ends the session (RUN → OVER in the same update that increments the count).
- **`MISS_LIMIT_EN` undefined:** only timer expiry ends the session. `MAX_MISS` is unused, and `miss_count` saturates at 255.

## Test plan
Benches use `READY_CYCLES` = 4, `TIMER_INIT` = 100 and `MISS_PENALTY` = 30.
- **Start sequence:** `reset` low for 2 cycles with `start` held high, then released and pressed. Expect:
  - no edge while held through reset;
  - on the press, `timer_load` = 1 with `load_value` = 100 for one cycle;
  - `state` = 1 for 4 cycles, then `state` = 2 with `timer_run` = 1.
- **Miss penalty:** RUN with `timer_in` = 70, `miss` pulse → `load_value` = 40 and `miss_count` = 1. RUN with `timer_in` = 20, `miss` pulse → `load_value` = 0.
- **Expiry priority:** RUN with `timer_in` = 0 and `miss` in the same cycle → `state` = 4, `game_over` = 1, `timer_run` = 0, `miss_count` unchanged, no `timer_load`.
- **Pause:** RUN, `pause` edge together with `hit` → `state` = 3, `timer_run` = 0, `hit_count` +1. A `miss` while in PAUSE is ignored. A second `pause` edge → `state` = 2, `timer_run` = 1.
- **Miss limit:** with `MISS_LIMIT_EN` and `MAX_MISS` = 3, three misses → `state` = 4 after the third. Without the macro, the same stimulus stays in RUN with `miss_count` = 3.
- **Restart and reset:** from OVER, a `start` edge → counts = 0, `game_over` = 0, `state` = 1. `reset` low during READY → IDLE with all outputs 0 on the next edge.
